// File: rtl/rv_lsu_if.sv
// rv_lsu_if: data-bus bundle between the load/store unit and memory.
//
// Signals:
//   bstart  transaction start, held high until bdone
//   ttype   0 = READ, 1 = WRITE
//   tsize   0 = BYTE, 1 = HALF, 2 = WORD
//   addr    beat byte address (ADDR_W bits)
//   wdata   write data already placed in its byte lanes
//   rdata   full-word read data, lanes selected by addr[1:0]
//   bdone   beat complete
//
// Modports: master (the LSU drives the request side), slave (memory side).

interface rv_lsu_if #(
   parameter int ADDR_W = 32
) ();

   logic              bstart;
   logic              ttype;
   logic [1:0]        tsize;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              bdone;

   modport master (
      output bstart, ttype, tsize, addr, wdata,
      input  rdata, bdone
   );

   modport slave (
      input  bstart, ttype, tsize, addr, wdata,
      output rdata, bdone
   );

endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit for the memory-access phase of the core.
//
// Accepts one load or store from execute, runs it over the bstart/bdone data
// bus, and returns a one-cycle response. Store data is placed in the correct
// byte lanes; load data is extracted from its lanes and sign/zero extended.
// Misaligned accesses are either split into byte beats or rejected, and an
// optional timeout aborts a beat whose bdone never arrives.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          RISC-V funct3 (size in [1:0], unsigned load in [2])
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            error flag, qualified by resp_valid
//   busy                high whenever the unit is not idle
//   bus                 data bus (rv_lsu_if.master)

module rv_lsu #(
   parameter int ADDR_W         = 32,
   parameter bit MISALIGN_SPLIT = 1'b1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   rv_lsu_if.master          bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic              cap_we;
   logic [2:0]        cap_funct3;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_wdata;
   logic              cap_split;
   logic              err_q;
   logic [1:0]        beat_q;
   logic              gap_q;
   logic [31:0]       to_cnt_q;
   logic [31:0]       asm_q;

   logic              req_f3_ok;
   logic              req_misaligned;
   logic              req_legal;

   logic [1:0]        last_idx;
   logic [ADDR_W-1:0] beat_addr;
   logic [1:0]        lane;
   logic              bstart_int;
   logic              last_beat;
   logic              beat_done;
   logic              timeout_hit;

   logic [31:0]       rd_shifted;
   logic [7:0]        rd_lane;
   logic [31:0]       wd_aligned;
   logic [31:0]       wd_lane;
   logic [31:0]       load_ext;

   // Decode the incoming request: a funct3 must name a real access, stores
   // cannot use the unsigned-load encodings, and a misaligned access is only
   // legal when the unit is built to split it into byte beats.
   always_comb begin
      req_f3_ok      = 1'b0;
      req_misaligned = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: req_f3_ok = 1'b1;
         3'b001, 3'b101: begin
            req_f3_ok      = 1'b1;
            req_misaligned = req_addr[0];
         end
         3'b010: begin
            req_f3_ok      = 1'b1;
            req_misaligned = |req_addr[1:0];
         end
         default: req_f3_ok = 1'b0;
      endcase
      req_legal = req_f3_ok && !(req_we && req_funct3[2]) &&
                  (MISALIGN_SPLIT || !req_misaligned);
   end

   // Per-beat control. bstart is suppressed for the single gap cycle that
   // follows each non-final beat. The timeout fires on the last waiting cycle
   // so that bstart stays high for exactly TIMEOUT_CYCLES cycles.
   always_comb begin
      case (cap_funct3[1:0])
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
      beat_addr   = cap_addr + ADDR_W'(beat_q);
      lane        = beat_addr[1:0];
      bstart_int  = (state_q == ACCESS) && !gap_q;
      last_beat   = !cap_split || (beat_q == last_idx);
      beat_done   = bstart_int && bus.bdone;
      timeout_hit = (TIMEOUT_CYCLES > 0) && bstart_int && !bus.bdone &&
                    (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
   end

   // Lane steering in both directions plus final load extension. Aligned
   // accesses shift the whole word; split accesses move one byte per beat
   // between byte index beat_q and lane (addr+beat_q)[1:0].
   always_comb begin
      rd_shifted = bus.rdata >> {cap_addr[1:0], 3'b000};
      rd_lane    = 8'(bus.rdata >> {lane, 3'b000});
      wd_aligned = cap_wdata << {cap_addr[1:0], 3'b000};
      wd_lane    = {24'h0, 8'(cap_wdata >> {beat_q, 3'b000})} << {lane, 3'b000};
      case (cap_funct3)
         3'b000:  load_ext = {{24{asm_q[7]}}, asm_q[7:0]};
         3'b001:  load_ext = {{16{asm_q[15]}}, asm_q[15:0]};
         3'b100:  load_ext = {24'h0, asm_q[7:0]};
         3'b101:  load_ext = {16'h0, asm_q[15:0]};
         default: load_ext = asm_q;
      endcase
   end

   // Next-state logic. Illegal requests skip the bus and go straight to the
   // response cycle; the response cycle always returns to idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = req_legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if ((beat_done && last_beat) || timeout_hit) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from state so that an asynchronous reset clears
   // bstart and any pending response in the same cycle. Bus fields are zero
   // whenever no beat is in flight.
   always_comb begin
      req_ready  = (state_q == IDLE);
      busy       = (state_q != IDLE);
      resp_valid = (state_q == RESP);
      resp_err   = (state_q == RESP) && err_q;
      resp_rdata = 32'h0;
      if ((state_q == RESP) && !err_q && !cap_we) begin
         resp_rdata = load_ext;
      end
      bus.bstart = bstart_int;
      bus.ttype  = bstart_int && cap_we;
      bus.tsize  = 2'b00;
      bus.addr   = '0;
      bus.wdata  = 32'h0;
      if (bstart_int) begin
         bus.tsize = cap_split ? 2'b00 : cap_funct3[1:0];
         bus.addr  = beat_addr;
         if (cap_we) begin
            bus.wdata = cap_split ? wd_lane : wd_aligned;
         end
      end
   end

   // State, request capture, beat sequencing, timeout counting and load
   // assembly. The request is latched once so later req_* changes are inert.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cap_we     <= 1'b0;
         cap_funct3 <= 3'b000;
         cap_addr   <= '0;
         cap_wdata  <= 32'h0;
         cap_split  <= 1'b0;
         err_q      <= 1'b0;
         beat_q     <= 2'd0;
         gap_q      <= 1'b0;
         to_cnt_q   <= 32'h0;
         asm_q      <= 32'h0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cap_we     <= req_we;
                  cap_funct3 <= req_funct3;
                  cap_addr   <= req_addr;
                  cap_wdata  <= req_wdata;
                  cap_split  <= req_misaligned;
                  err_q      <= !req_legal;
                  beat_q     <= 2'd0;
                  gap_q      <= 1'b0;
                  to_cnt_q   <= 32'h0;
                  asm_q      <= 32'h0;
               end
            end
            ACCESS: begin
               if (gap_q) begin
                  gap_q <= 1'b0;
               end else if (bus.bdone) begin
                  to_cnt_q <= 32'h0;
                  if (!cap_we) begin
                     if (cap_split) begin
                        case (beat_q)
                           2'd0:    asm_q[7:0]   <= rd_lane;
                           2'd1:    asm_q[15:8]  <= rd_lane;
                           2'd2:    asm_q[23:16] <= rd_lane;
                           default: asm_q[31:24] <= rd_lane;
                        endcase
                     end else begin
                        asm_q <= rd_shifted;
                     end
                  end
                  if (!last_beat) begin
                     beat_q <= beat_q + 2'd1;
                     gap_q  <= 1'b1;
                  end
               end else if (TIMEOUT_CYCLES > 0) begin
                  to_cnt_q <= to_cnt_q + 32'd1;
                  if (timeout_hit) begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: self-checking bench for rv_lsu.
//
// dut_a: MISALIGN_SPLIT=1, TIMEOUT_CYCLES=8, driven by a bus responder with a
//        programmable number of wait states and per-beat read words.
// dut_b: MISALIGN_SPLIT=0, TIMEOUT_CYCLES=0, bdone tied to bstart.
// Expected responses are queued when a request is issued and popped when
// the DUT pulses resp_valid.

module tb_rv_lsu;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic              a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err, a_busy;
   logic [2:0]        a_req_funct3;
   logic [ADDR_W-1:0] a_req_addr;
   logic [31:0]       a_req_wdata, a_resp_rdata;
   logic              b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err, b_busy;
   logic [2:0]        b_req_funct3;
   logic [ADDR_W-1:0] b_req_addr;
   logic [31:0]       b_req_wdata, b_resp_rdata;

   rv_lsu_if #(.ADDR_W(ADDR_W)) bus_a ();
   rv_lsu_if #(.ADDR_W(ADDR_W)) bus_b ();

   rv_lsu #(.ADDR_W(ADDR_W), .MISALIGN_SPLIT(1'b1), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
      .busy(a_busy), .bus(bus_a)
   );

   rv_lsu #(.ADDR_W(ADDR_W), .MISALIGN_SPLIT(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
      .busy(b_busy), .bus(bus_b)
   );

   assign bus_b.bdone = bus_b.bstart;
   assign bus_b.rdata = 32'h1234_5678;

   // Responder state for dut_a; tasks only write the configuration variables.
   int                wait_states = 0;
   int                rd_base = 0;
   logic [31:0]       rd_words[$];
   int                hi_cnt = 0;
   int                a_bstart_cycles = 0;
   int                b_bstart_cycles = 0;
   logic [ADDR_W-1:0] log_addr[$];
   logic [1:0]        log_size[$];
   logic              log_type[$];
   logic [31:0]       log_wdata[$];
   int                log_start[$];
   logic [31:0]       exp_rd_q[$];
   logic              exp_err_q[$];

   // Beat logger and responder for dut_a: bdone after wait_states cycles of
   // bstart, returning the word queued for this beat of the current request.
   always @(negedge clk) begin
      if (bus_a.bstart) begin
         if (hi_cnt == 0) begin
            log_addr.push_back(bus_a.addr);
            log_size.push_back(bus_a.tsize);
            log_type.push_back(bus_a.ttype);
            log_wdata.push_back(bus_a.wdata);
            log_start.push_back(cyc);
         end
         hi_cnt++;
         a_bstart_cycles++;
         if (hi_cnt > wait_states) begin
            int k;
            k = log_start.size() - 1 - rd_base;
            bus_a.bdone = 1'b1;
            bus_a.rdata = (k >= 0 && k < rd_words.size()) ? rd_words[k] : 32'h0;
         end else begin
            bus_a.bdone = 1'b0;
         end
      end else begin
         hi_cnt      = 0;
         bus_a.bdone = 1'b0;
      end
   end

   // Count every cycle dut_b drives bstart.
   always @(negedge clk) begin
      if (bus_b.bstart) b_bstart_cycles++;
   end

   // Drive one request and hold it for the accepting edge, then scramble the
   // request inputs. acc is the cycle stamp seen in cycle 1 of the access.
   task automatic issue(input bit use_b, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, output int acc);
      @(negedge clk);
      if (use_b) begin
         b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
      end else begin
         a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
      end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      a_req_we = 1'($urandom_range(0, 1)); a_req_funct3 = 3'($urandom_range(0, 7));
      a_req_addr = $urandom; a_req_wdata = $urandom;
      b_req_we = 1'($urandom_range(0, 1)); b_req_funct3 = 3'($urandom_range(0, 7));
      b_req_addr = $urandom; b_req_wdata = $urandom;
      acc = cyc;
   endtask

   // Wait a bounded number of cycles for resp_valid and report what was seen.
   task automatic wait_resp(input bit use_b, input int max_cycles, output bit got,
                            output logic [31:0] rd, output logic er, output int rc);
      got = 1'b0; rd = 32'h0; er = 1'b0; rc = 0;
      for (int i = 0; i < max_cycles && !got; i++) begin
         @(negedge clk);
         if (use_b ? b_resp_valid : a_resp_valid) begin
            got = 1'b1;
            rd  = use_b ? b_resp_rdata : a_resp_rdata;
            er  = use_b ? b_resp_err : a_resp_err;
            rc  = cyc;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({a_req_ready, a_resp_valid, a_busy, bus_a.bstart, bus_a.ttype, bus_a.tsize, a_resp_err} !== 8'b1000_0000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got=%b exp=10000000",
                  {a_req_ready, a_resp_valid, a_busy, bus_a.bstart, bus_a.ttype, bus_a.tsize, a_resp_err});
      end
      checks++;
      if ({bus_a.addr, bus_a.wdata, a_resp_rdata} !== 96'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got=%h exp=0", {bus_a.addr, bus_a.wdata, a_resp_rdata});
      end
      checks++;
      if ({b_req_ready, b_busy, bus_b.bstart} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_dut_b got=%b exp=100", {b_req_ready, b_busy, bus_b.bstart});
      end
   endtask

   // One aligned single-beat load on dut_a with its own read word.
   task automatic one_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] exp, input int ws);
      int acc, rc, base;
      bit got;
      logic [31:0] rd, e_rd;
      logic er, e_er;
      wait_states = ws;
      base = log_start.size();
      rd_base = base;
      rd_words.delete();
      rd_words.push_back(word);
      exp_rd_q.push_back(exp);
      exp_err_q.push_back(1'b0);
      issue(1'b0, 1'b0, f3, addr, 32'h0, acc);
      wait_resp(1'b0, 40, got, rd, er, rc);
      e_rd = exp_rd_q.pop_front();
      e_er = exp_err_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL load_resp f3=%b addr=%h got=none exp=resp_valid", f3, addr);
      end else begin
         checks++;
         if (rd !== e_rd) begin errors++; $display("[TB] FAIL load_rdata f3=%b addr=%h got=%h exp=%h", f3, addr, rd, e_rd); end
         checks++;
         if (er !== e_er) begin errors++; $display("[TB] FAIL load_err f3=%b got=%b exp=%b", f3, er, e_er); end
         checks++;
         if (rc - acc + 1 != 2 + ws) begin errors++; $display("[TB] FAIL load_latency got=%0d exp=%0d", rc - acc + 1, 2 + ws); end
      end
      checks++;
      if (log_start.size() - base != 1) begin
         errors++;
         $display("[TB] FAIL load_beats got=%0d exp=1", log_start.size() - base);
      end else begin
         checks++;
         if ({log_addr[base], log_size[base], log_type[base]} !== {addr, f3[1:0], 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_beat_fields got=%h/%0d/%b exp=%h/%0d/0", log_addr[base], log_size[base], log_type[base], addr, f3[1:0]);
         end
         checks++;
         if (log_start[base] - acc + 1 != 1) begin
            errors++;
            $display("[TB] FAIL load_first_bstart got=%0d exp=1", log_start[base] - acc + 1);
         end
      end
   endtask

   task automatic test_aligned_load();
      one_load(3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);
      one_load(3'b000, 32'h203, 32'h8000_0000, 32'hFFFF_FF80, 0);
      one_load(3'b100, 32'h203, 32'h8000_0000, 32'h0000_0080, 1);
      one_load(3'b101, 32'h202, 32'hF0F0_0000, 32'h0000_F0F0, 2);
      one_load(3'b001, 32'h202, 32'h8001_0000, 32'hFFFF_8001, 0);
      one_load(3'b000, 32'h001, 32'h0000_7F00, 32'h0000_007F, 1);
      one_load(3'b010, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
   endtask

   // Stores on dut_a: single beat, write data shifted into lane addr[1:0].
   task automatic test_store();
      logic [2:0]  f3s [4];
      logic [31:0] ads [4];
      logic [31:0] wds [4];
      logic [31:0] exw [4];
      f3s[0] = 3'b001; ads[0] = 32'h306; wds[0] = 32'h0000_ABCD; exw[0] = 32'hABCD_0000;
      f3s[1] = 3'b000; ads[1] = 32'h101; wds[1] = 32'h1234_5678; exw[1] = 32'h3456_7800;
      f3s[2] = 3'b010; ads[2] = 32'h200; wds[2] = 32'h89AB_CDEF; exw[2] = 32'h89AB_CDEF;
      f3s[3] = 3'b000; ads[3] = 32'h003; wds[3] = 32'h0000_00EE; exw[3] = 32'hEE00_0000;
      wait_states = 1;
      for (int i = 0; i < 4; i++) begin
         int acc, rc, base;
         bit got;
         logic [31:0] rd, e_rd;
         logic er, e_er;
         base = log_start.size();
         rd_base = base;
         rd_words.delete();
         exp_rd_q.push_back(32'h0);
         exp_err_q.push_back(1'b0);
         issue(1'b0, 1'b1, f3s[i], ads[i], wds[i], acc);
         wait_resp(1'b0, 40, got, rd, er, rc);
         e_rd = exp_rd_q.pop_front();
         e_er = exp_err_q.pop_front();
         checks++;
         if (!got || rd !== e_rd || er !== e_er || rc - acc + 1 != 3) begin
            errors++;
            $display("[TB] FAIL store_resp i=%0d got=%b/%h/%b/%0d exp=1/%h/%b/3", i, got, rd, er, rc - acc + 1, e_rd, e_er);
         end
         checks++;
         if (log_start.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL store_beats i=%0d got=%0d exp=1", i, log_start.size() - base);
         end else begin
            checks++;
            if ({log_addr[base], log_size[base], log_type[base], log_wdata[base]} !== {ads[i], f3s[i][1:0], 1'b1, exw[i]}) begin
               errors++;
               $display("[TB] FAIL store_beat i=%0d got=%h/%0d/%b/%h exp=%h/%0d/1/%h", i, log_addr[base], log_size[base],
                        log_type[base], log_wdata[base], ads[i], f3s[i][1:0], exw[i]);
            end
         end
      end
   endtask

   // Misaligned accesses on dut_a become byte beats with one idle cycle in
   // between; each beat's fields are checked against a lane model.
   task automatic test_split();
      logic        wes [3];
      logic [2:0]  f3s [3];
      logic [31:0] ads [3];
      logic [31:0] wds [3];
      logic [31:0] exr [3];
      int          wss [3];
      int          nb  [3];
      wes[0] = 1'b0; f3s[0] = 3'b010; ads[0] = 32'h103; wds[0] = 32'h0;         exr[0] = 32'h4433_2211; wss[0] = 0; nb[0] = 4;
      wes[1] = 1'b1; f3s[1] = 3'b010; ads[1] = 32'h0FE; wds[1] = 32'hA1B2_C3D4; exr[1] = 32'h0;         wss[1] = 1; nb[1] = 4;
      wes[2] = 1'b0; f3s[2] = 3'b001; ads[2] = 32'h1FF; wds[2] = 32'h0;         exr[2] = 32'hFFFF_FF80; wss[2] = 0; nb[2] = 2;
      for (int t = 0; t < 3; t++) begin
         int acc, rc, base;
         bit got;
         logic [31:0] rd, e_rd;
         logic er, e_er;
         wait_states = wss[t];
         base = log_start.size();
         rd_base = base;
         rd_words.delete();
         if (t == 0) begin
            rd_words.push_back(32'h11A5_A5A5); rd_words.push_back(32'hA5A5_A522);
            rd_words.push_back(32'hA5A5_33A5); rd_words.push_back(32'hA544_A5A5);
         end else if (t == 2) begin
            rd_words.push_back(32'h80A5_A5A5); rd_words.push_back(32'hA5A5_A5FF);
         end
         exp_rd_q.push_back(exr[t]);
         exp_err_q.push_back(1'b0);
         issue(1'b0, wes[t], f3s[t], ads[t], wds[t], acc);
         wait_resp(1'b0, 80, got, rd, er, rc);
         e_rd = exp_rd_q.pop_front();
         e_er = exp_err_q.pop_front();
         checks++;
         if (!got || rd !== e_rd || er !== e_er) begin
            errors++;
            $display("[TB] FAIL split_resp t=%0d got=%b/%h/%b exp=1/%h/%b", t, got, rd, er, e_rd, e_er);
         end
         checks++;
         if (got && rc - acc + 1 != nb[t] * (wss[t] + 2)) begin
            errors++;
            $display("[TB] FAIL split_latency t=%0d got=%0d exp=%0d", t, rc - acc + 1, nb[t] * (wss[t] + 2));
         end
         checks++;
         if (log_start.size() - base != nb[t]) begin
            errors++;
            $display("[TB] FAIL split_beats t=%0d got=%0d exp=%0d", t, log_start.size() - base, nb[t]);
         end else begin
            for (int i = 0; i < nb[t]; i++) begin
               logic [31:0] ba, ew;
               ba = ads[t] + 32'(i);
               ew = wes[t] ? ({24'h0, 8'(wds[t] >> (8 * i))} << (8 * ba[1:0])) : 32'h0;
               checks++;
               if ({log_addr[base+i], log_size[base+i], log_type[base+i], log_wdata[base+i]} !== {ba, 2'b00, wes[t], ew}) begin
                  errors++;
                  $display("[TB] FAIL split_beat t=%0d i=%0d got=%h/%0d/%b/%h exp=%h/0/%b/%h", t, i, log_addr[base+i],
                           log_size[base+i], log_type[base+i], log_wdata[base+i], ba, wes[t], ew);
               end
               if (i > 0) begin
                  checks++;
                  if (log_start[base+i] - log_start[base+i-1] != wss[t] + 2) begin
                     errors++;
                     $display("[TB] FAIL split_gap t=%0d i=%0d got=%0d exp=%0d", t, i,
                              log_start[base+i] - log_start[base+i-1], wss[t] + 2);
                  end
               end
            end
         end
      end
   endtask

   // dut_b rejects misaligned accesses at cycle 1 without touching the bus,
   // but still performs aligned ones normally.
   task automatic test_misalign_reject();
      logic        wes [4];
      logic [2:0]  f3s [4];
      logic [31:0] ads [4];
      logic [31:0] exr [4];
      logic        exe [4];
      int          exl [4];
      wes[0] = 1'b0; f3s[0] = 3'b010; ads[0] = 32'h103; exr[0] = 32'h0;         exe[0] = 1'b1; exl[0] = 1;
      wes[1] = 1'b1; f3s[1] = 3'b001; ads[1] = 32'h101; exr[1] = 32'h0;         exe[1] = 1'b1; exl[1] = 1;
      wes[2] = 1'b0; f3s[2] = 3'b010; ads[2] = 32'h100; exr[2] = 32'h1234_5678; exe[2] = 1'b0; exl[2] = 2;
      wes[3] = 1'b0; f3s[3] = 3'b101; ads[3] = 32'h102; exr[3] = 32'h0000_1234; exe[3] = 1'b0; exl[3] = 2;
      for (int t = 0; t < 4; t++) begin
         int acc, rc, snap;
         bit got;
         logic [31:0] rd, e_rd;
         logic er, e_er;
         snap = b_bstart_cycles;
         exp_rd_q.push_back(exr[t]);
         exp_err_q.push_back(exe[t]);
         issue(1'b1, wes[t], f3s[t], ads[t], 32'h5555_AAAA, acc);
         wait_resp(1'b1, 20, got, rd, er, rc);
         e_rd = exp_rd_q.pop_front();
         e_er = exp_err_q.pop_front();
         checks++;
         if (!got || rd !== e_rd || er !== e_er || rc - acc + 1 != exl[t]) begin
            errors++;
            $display("[TB] FAIL nosplit_resp t=%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d", t, got, rd, er, rc - acc + 1, e_rd, e_er, exl[t]);
         end
         checks++;
         if ((b_bstart_cycles - snap) != (exe[t] ? 0 : 1)) begin
            errors++;
            $display("[TB] FAIL nosplit_bstart t=%0d got=%0d exp=%0d", t, b_bstart_cycles - snap, exe[t] ? 0 : 1);
         end
      end
   endtask

   // Illegal encodings on dut_a: error at cycle 1, no bus activity.
   task automatic test_illegal();
      logic [3:0] cmd [3];
      cmd[0] = 4'b0110;
      cmd[1] = 4'b0011;
      cmd[2] = 4'b1100;
      for (int t = 0; t < 3; t++) begin
         int acc, rc, snap;
         bit got;
         logic [31:0] rd, e_rd;
         logic er, e_er;
         snap = a_bstart_cycles;
         exp_rd_q.push_back(32'h0);
         exp_err_q.push_back(1'b1);
         issue(1'b0, cmd[t][3], cmd[t][2:0], 32'h200, 32'hFFFF_FFFF, acc);
         wait_resp(1'b0, 20, got, rd, er, rc);
         e_rd = exp_rd_q.pop_front();
         e_er = exp_err_q.pop_front();
         checks++;
         if (!got || rd !== e_rd || er !== e_er || rc - acc + 1 != 1) begin
            errors++;
            $display("[TB] FAIL illegal_resp cmd=%b got=%b/%h/%b/%0d exp=1/%h/%b/1", cmd[t], got, rd, er, rc - acc + 1, e_rd, e_er);
         end
         checks++;
         if (a_bstart_cycles != snap) begin
            errors++;
            $display("[TB] FAIL illegal_bstart cmd=%b got=%0d exp=0", cmd[t], a_bstart_cycles - snap);
         end
      end
   endtask

   // bdone never arrives: bstart high for 8 cycles, then an error response.
   task automatic test_timeout();
      int acc, rc, snap;
      bit got;
      logic [31:0] rd, e_rd;
      logic er, e_er, bs;
      wait_states = 1000;
      rd_base = log_start.size();
      rd_words.delete();
      rd_words.push_back(32'h7777_7777);
      snap = a_bstart_cycles;
      exp_rd_q.push_back(32'h0);
      exp_err_q.push_back(1'b1);
      issue(1'b0, 1'b0, 3'b010, 32'h400, 32'h0, acc);
      wait_resp(1'b0, 40, got, rd, er, rc);
      bs = bus_a.bstart;
      e_rd = exp_rd_q.pop_front();
      e_er = exp_err_q.pop_front();
      checks++;
      if (!got || rd !== e_rd || er !== e_er || bs !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_resp got=%b/%h/%b/bstart=%b exp=1/%h/%b/bstart=0", got, rd, er, bs, e_rd, e_er);
      end
      checks++;
      if (got && rc - acc + 1 != 9) begin
         errors++;
         $display("[TB] FAIL timeout_latency got=%0d exp=9", rc - acc + 1);
      end
      checks++;
      if (a_bstart_cycles - snap != 8) begin
         errors++;
         $display("[TB] FAIL timeout_bstart_cycles got=%0d exp=8", a_bstart_cycles - snap);
      end
      @(negedge clk);
      checks++;
      if (a_req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_ready got=%b exp=1", a_req_ready);
      end
      wait_states = 0;
   endtask

   // Reset in the middle of the second beat of a split store.
   task automatic test_reset_mid_beat();
      int acc, base, seen;
      wait_states = 5;
      base = log_start.size();
      rd_base = base;
      rd_words.delete();
      issue(1'b0, 1'b1, 3'b010, 32'h201, 32'h0BAD_F00D, acc);
      for (int i = 0; i < 40 && log_start.size() - base < 2; i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus_a.bstart !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_setup_bstart got=%b exp=1", bus_a.bstart);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus_a.bstart, a_req_ready, a_busy, a_resp_valid} !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL rst_async got=%b exp=0100", {bus_a.bstart, a_req_ready, a_busy, a_resp_valid});
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (a_resp_valid) seen++;
      end
      checks++;
      if (seen != 0 || a_req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_discard got=%0d/%b exp=0/1", seen, a_req_ready);
      end
      wait_states = 0;
      one_load(3'b010, 32'h500, 32'h0123_4567, 32'h0123_4567, 0);
   endtask

   initial begin
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b000; a_req_addr = '0; a_req_wdata = 32'h0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b000; b_req_addr = '0; b_req_wdata = 32'h0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_aligned_load();
      test_store();
      test_split();
      test_misalign_reject();
      test_illegal();
      test_timeout();
      test_reset_mid_beat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
Parametrised load/store unit that owns the core's memory-access phase. It accepts one load or store request from the execute stage and drives the data bus through the bstart/bdone handshake. It places store data in the correct byte lanes and extracts and sign- or zero-extends load data. Misaligned accesses are either trapped or split into byte beats, and a stalled bus is aborted by a timeout.

Parameters:
ADDR_W, 32, width of request and bus addresses
MISALIGN_SPLIT, 1, 1 = split misaligned accesses into byte beats; 0 = reject them with resp_err
TIMEOUT_CYCLES, 0, maximum cycles bstart may wait for bdone on one beat; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  ISA funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid
busy  out  1  state != IDLE
bus_bstart  out  1  transaction start, held until bdone
bus_ttype  out  1  0 READ, 1 WRITE
bus_tsize  out  2  0 BYTE, 1 HALF, 2 WORD
bus_addr  out  ADDR_W  beat address
bus_wdata  out  32  lane-placed write data
bus_rdata  in  32  full-word read data, lanes by addr[1:0]
bus_bdone  in  1  beat complete

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State is IDLE. Beat counter, timeout counter and assembly register are 0.
- The request is captured on any cycle with req_valid && req_ready. Address, we, funct3 and wdata are registered; later changes to the req_* inputs have no effect.
- FSM states:
  - IDLE -> ACCESS on an accepted legal request.
  - IDLE -> RESP on an illegal request (err=1, no bus activity).
  - ACCESS -> ACCESS on each bdone that is not the last beat.
  - ACCESS -> RESP on bdone of the last beat, or on timeout (err=1).
  - RESP -> IDLE unconditionally.
- Illegal requests:
  - funct3 of 011, 110 or 111.
  - A store with funct3[2]=1.
  - A misaligned access while MISALIGN_SPLIT=0.
- Size and alignment: size is 1, 2 or 4 bytes from funct3[1:0]. An access is misaligned when addr mod size != 0.
- Aligned access: one beat with bus_addr = captured addr and bus_tsize = funct3[1:0].
  - Stores: bus_wdata = req_wdata shifted left by 8*addr[1:0].
  - Loads: the result is taken from bus_rdata shifted right by 8*addr[1:0].
- Split access: N = size beats, i = 0..N-1, bus_addr = addr+i (ADDR_W wrap-around permitted), bus_tsize = BYTE.
  - Stores: wdata byte i is placed in lane (addr+i)[1:0].
  - Loads: byte lane (addr+i)[1:0] of bus_rdata is written into assembly byte i on that beat's bdone.
- Beat handshake:
  - bus_bstart is high for every ACCESS cycle of a beat, including the bdone cycle.
  - It drops for exactly one cycle between beats, then the next beat starts.
  - bus_ttype = captured we.
  - bus_bdone is ignored outside ACCESS.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Latency: request accepted at cycle 0, first bstart at cycle 1. resp_valid is issued in the cycle after the final bdone. Minimum request-to-response is 2 cycles plus bus wait states per beat.
- Timeout: when TIMEOUT_CYCLES > 0, the timeout counter increments on each ACCESS cycle without bdone.
  - At count == TIMEOUT_CYCLES the beat aborts: bstart drops, state -> RESP, resp_err=1, rdata=0.
  - The counter clears on each bdone.
- Store response: resp_rdata = 0, err = 0 on success.
- rst asserted in any state: state returns to IDLE immediately (asynchronous) and bus_bstart drops in the same cycle. A pending response is discarded.

Test Plan:
- LW at 0x100, bus_rdata=0xDEADBEEF, bdone 3 cycles after bstart -> one beat (tsize=2, addr=0x100), resp_valid 1 cycle after bdone, rdata=0xDEADBEEF, err=0.
- LB at 0x203 with rdata=0x80000000 -> rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x202 with rdata=0xF0F00000 -> 0x0000F0F0.
- SH at 0x306, wdata=0x0000ABCD -> one beat, tsize=1, ttype=1, bus_wdata=0xABCD0000.
- MISALIGN_SPLIT=1, LW at 0x103, lanes return bytes 0x11,0x22,0x33,0x44 -> 4 BYTE beats at 0x103..0x106 with one idle cycle between beats, rdata=0x44332211. With MISALIGN_SPLIT=0 -> no bstart, resp_err=1 at cycle 1.
- TIMEOUT_CYCLES=8, bdone held low -> bstart high for 8 cycles then low, resp_err=1, rdata=0, req_ready high the next cycle.
- Reset: rst pulsed mid-beat of a split store -> bstart low in the same cycle, no resp_valid, req_ready=1. funct3=110 request -> resp_err=1, no bus activity.
